// File: rtl/tick_counter.sv
// ============================================================================
//  Module   : tick_counter
//  Brief    : Parametrised prescaled up/down event counter with wrap/saturate,
//             parallel load, and registered tick / wrap strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_counter #(
  parameter int INPUT_CLOCK_HZ = 27000000,
  parameter int INC_TIME_MS    = 1000,
  parameter int WIDTH          = 8,
  parameter int MODULO         = 256,
  parameter bit SATURATE       = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_value,
  output logic             o_tick,
  output logic             o_wrap,
  output logic             o_at_limit
);

  localparam int             c_DIV        = INPUT_CLOCK_HZ / 1000 * INC_TIME_MS;
  localparam int             c_PW         = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(c_DIV - 1);
  localparam logic [WIDTH:0]   c_MAX        = (WIDTH + 1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] c_MAX_V      = WIDTH'(MODULO - 1);

  if (c_DIV < 1) begin : g_chk_div
    $fatal(1, "tick_counter: DIV must be >= 1");
  end
  if (MODULO < 2) begin : g_chk_mod_lo
    $fatal(1, "tick_counter: MODULO must be >= 2");
  end
  if (MODULO > (2 ** WIDTH)) begin : g_chk_mod_hi
    $fatal(1, "tick_counter: MODULO must be <= 2**WIDTH");
  end

  logic [c_PW-1:0]  r_presc;
  logic [WIDTH-1:0] r_value;
  logic             r_tick;
  logic             r_wrap;

  logic [WIDTH:0]   w_val_ext;
  logic [WIDTH:0]   w_load_ext;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;
  logic             w_hit;
  logic [WIDTH-1:0] w_next;

  assign w_val_ext      = {1'b0, r_value};
  assign w_load_ext     = {1'b0, i_load_value};
  assign w_load_clamped = (w_load_ext > c_MAX) ? c_MAX_V : i_load_value;
  assign w_step         = i_enable && (r_presc == c_PRESC_LAST);
  assign w_hit          = i_up ? (w_val_ext == c_MAX) : (w_val_ext == '0);

  // At a limit: saturate holds the value, otherwise jump to the opposite end.
  always_comb begin
    w_next = r_value;
    if (w_hit) begin
      if (!SATURATE) begin
        w_next = i_up ? '0 : c_MAX_V;
      end
    end else if (i_up) begin
      w_next = WIDTH'(w_val_ext + (WIDTH + 1)'(1));
    end else begin
      w_next = WIDTH'(w_val_ext - (WIDTH + 1)'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_value <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (i_load) begin
      r_presc <= '0;
      r_value <= w_load_clamped;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (i_enable) begin
      r_tick <= w_step;
      r_wrap <= w_step && w_hit;
      if (w_step) begin
        r_presc <= '0;
        r_value <= w_next;
      end else begin
        r_presc <= r_presc + c_PW'(1);
      end
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign o_value    = r_value;
  assign o_tick     = r_tick;
  assign o_wrap     = r_wrap;
  assign o_at_limit = i_up ? (r_value == c_MAX_V) : (r_value == '0);

endmodule

`default_nettype wire

// File: tb/tb_tick_counter.sv
// ============================================================================
//  Module   : tb_tick_counter
//  Brief    : Directed, table-driven self-checking bench for tick_counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, ld;
  logic [3:0] lv;

  logic [3:0] v0, vs, v1;
  logic       t0, ts, t1, w0, ws, w1, l0, ls, l1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // DIV=4 wrap, DIV=4 saturate, DIV=1 wrap; all share the same stimulus.
  tick_counter #(.INPUT_CLOCK_HZ(4000), .INC_TIME_MS(1), .WIDTH(4), .MODULO(10), .SATURATE(1'b0))
    u_wrap (.i_clk(clk), .i_rst(rst), .i_enable(en), .i_up(up), .i_load(ld), .i_load_value(lv),
            .o_value(v0), .o_tick(t0), .o_wrap(w0), .o_at_limit(l0));
  tick_counter #(.INPUT_CLOCK_HZ(4000), .INC_TIME_MS(1), .WIDTH(4), .MODULO(10), .SATURATE(1'b1))
    u_sat (.i_clk(clk), .i_rst(rst), .i_enable(en), .i_up(up), .i_load(ld), .i_load_value(lv),
           .o_value(vs), .o_tick(ts), .o_wrap(ws), .o_at_limit(ls));
  tick_counter #(.INPUT_CLOCK_HZ(1000), .INC_TIME_MS(1), .WIDTH(4), .MODULO(10), .SATURATE(1'b0))
    u_div1 (.i_clk(clk), .i_rst(rst), .i_enable(en), .i_up(up), .i_load(ld), .i_load_value(lv),
            .o_value(v1), .o_tick(t1), .o_wrap(w1), .o_at_limit(l1));

  typedef struct {
    logic       rst, en, up, ld;
    logic [3:0] lv;
    logic [3:0] ev;
    logic       et, ew, el;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] v, input logic [3:0] xv,
                     input logic xt, input logic xw, input logic xl);
    vec_t x;
    x.rst = r; x.en = e; x.up = u; x.ld = l; x.lv = v;
    x.ev = xv; x.et = xt; x.ew = xw; x.el = xl;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ld = 1'b0; lv = '0;
    @(posedge clk); #1;
    chk("rst_value", 0, int'(v0), 0);
    chk("rst_tick",  0, int'(t0), 0);
    chk("rst_wrap",  0, int'(w0), 0);
    chk("rst_sat_value", 0, int'(vs), 0);
    chk("rst_div1_value", 0, int'(v1), 0);
    rst = 1'b0;
  endtask

  initial begin
    int n, ev;
    bit tk;
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; lv = '0;

    // Up count for 60 enabled edges: wrap, saturate and DIV=1 models side by side.
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      n  = k / 4;
      tk = (k % 4) == 0;
      ev = n % 10;
      chk("up_value", k, int'(v0), ev);
      chk("up_tick",  k, int'(t0), int'(tk));
      chk("up_wrap",  k, int'(w0), int'(tk && ev == 0));
      chk("up_limit", k, int'(l0), int'(ev == 9));
      chk("sat_value", k, int'(vs), (n > 9) ? 9 : n);
      chk("sat_tick",  k, int'(ts), int'(tk));
      chk("sat_wrap",  k, int'(ws), int'(tk && n >= 10));
      chk("div1_value", k, int'(v1), k % 10);
      chk("div1_tick",  k, int'(t1), 1);
      chk("div1_wrap",  k, int'(w1), int'((k % 10) == 0));
    end

    // Down count from reset: first step lands on 9 with a wrap pulse.
    do_reset();
    en = 1'b1; up = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      n  = k / 4;
      tk = (k % 4) == 0;
      ev = (10 - (n % 10)) % 10;
      chk("dn_value", k, int'(v0), ev);
      chk("dn_tick",  k, int'(t0), int'(tk));
      chk("dn_wrap",  k, int'(w0), int'(tk && n == 1));
      chk("dn_limit", k, int'(l0), int'(ev == 0));
      chk("dn_sat_value", k, int'(vs), 0);
      chk("dn_sat_wrap",  k, int'(ws), int'(tk));
    end

    // Load, enable and reset corner cases for the DIV=4 wrap instance.
    //   rst en up ld lv  | value tick wrap limit
    add(1, 0, 1, 0, 0,    0, 0, 0, 0);
    add(0, 1, 1, 0, 0,    0, 0, 0, 0);
    add(0, 1, 1, 0, 0,    0, 0, 0, 0);
    add(0, 1, 1, 1, 7,    7, 0, 0, 0);  // load at phase 2
    add(0, 1, 1, 0, 0,    7, 0, 0, 0);
    add(0, 1, 1, 0, 0,    7, 0, 0, 0);
    add(0, 1, 1, 0, 0,    7, 0, 0, 0);
    add(0, 1, 1, 0, 0,    8, 1, 0, 0);
    add(0, 1, 1, 1, 12,   9, 0, 0, 1);  // clamp
    add(0, 1, 1, 0, 0,    9, 0, 0, 1);
    add(0, 1, 1, 0, 0,    9, 0, 0, 1);
    add(0, 1, 1, 0, 0,    9, 0, 0, 1);
    add(0, 1, 1, 1, 3,    3, 0, 0, 0);  // load beats step
    add(0, 1, 1, 0, 0,    3, 0, 0, 0);
    add(0, 1, 1, 0, 0,    3, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, 3, 0, 0, 0);
    add(0, 1, 1, 0, 0,    3, 0, 0, 0);
    add(0, 1, 1, 0, 0,    4, 1, 0, 0);
    add(0, 0, 1, 0, 0,    4, 0, 0, 0);
    add(0, 0, 1, 1, 6,    6, 0, 0, 0);  // load while disabled
    add(0, 1, 1, 0, 0,    6, 0, 0, 0);
    add(1, 1, 1, 1, 5,    0, 0, 0, 0);  // reset beats load
    add(0, 1, 1, 0, 0,    0, 0, 0, 0);
    add(0, 1, 1, 0, 0,    0, 0, 0, 0);
    add(0, 1, 1, 0, 0,    0, 0, 0, 0);
    add(0, 1, 1, 0, 0,    1, 1, 0, 0);
    add(0, 0, 1, 1, 9,    9, 0, 0, 1);
    add(0, 0, 0, 0, 0,    9, 0, 0, 0);  // limit follows i_up at once
    add(0, 0, 0, 1, 0,    0, 0, 0, 1);
    add(0, 1, 0, 0, 0,    0, 0, 0, 1);
    add(0, 1, 0, 0, 0,    0, 0, 0, 1);
    add(0, 1, 0, 0, 0,    0, 0, 0, 1);
    add(0, 1, 0, 0, 0,    9, 1, 1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
      ld  = vecs[i].ld;  lv = vecs[i].lv;
      @(posedge clk); #1;
      chk("vec_value", i, int'(v0), int'(vecs[i].ev));
      chk("vec_tick",  i, int'(t0), int'(vecs[i].et));
      chk("vec_wrap",  i, int'(w0), int'(vecs[i].ew));
      chk("vec_limit", i, int'(l0), int'(vecs[i].el));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
